aes_key_expansion: RTL and testbench
====================================

Name: aes_key_expansion

Overview:
- Iterative AES-128 key schedule feeding AddRoundKeys.
- Latches a 128-bit cipher key on a start pulse and produces round keys 0..10, one per accepted handshake.
- A round key is presented on oRoundKey with its index, so the round controller can drive AddRoundKeys.iRoundKey directly.
- Generates the next round key from the current one, so no full schedule is stored by default.

Parameters:
- NR, 10, number of rounds. Only 10 is supported; any other value is an elaboration error.

Ports:
- iClk  input  1  system clock, rising edge.
- iRst_n  input  1  asynchronous active-low reset.
- iStart  input  1  one-cycle request to begin expansion of iKey.
- iKey  input  128  cipher key; sampled only in the cycle iStart is accepted.
- iKeyReady  input  1  consumer accepts the current round key.
- oRoundKey  output  128  current round key, big-endian byte order, w0 in [127:96].
- oRoundIdx  output  4  index of oRoundKey, 0..10.
- oKeyValid  output  1  oRoundKey/oRoundIdx valid.
- oBusy  output  1  expansion in progress (RUN state).
- oDone  output  1  one-cycle pulse after round key 10 is accepted.

Behaviour:
- Reset (async assert, sync deassert):
  - oRoundKey=0, oRoundIdx=0, oKeyValid=0, oBusy=0, oDone=0.
  - Rcon register=8'h01; state=IDLE.
- States: IDLE, RUN.
- IDLE:
  - iStart=1 -> next edge: oRoundKey<=iKey, oRoundIdx<=0, oKeyValid<=1, oBusy<=1, state->RUN.
  - Latency from start to round key 0 valid: 1 cycle.
- RUN:
  - Handshake: a key transfers on any edge with oKeyValid&iKeyReady.
  - While iKeyReady=0, oRoundKey, oRoundIdx and oKeyValid hold stable.
  - On transfer with oRoundIdx<10, the next edge loads the next round key, oRoundIdx+1, oKeyValid stays 1. One round key per cycle at full throughput.
  - On transfer with oRoundIdx==10, the next edge clears oKeyValid and oBusy, pulses oDone=1 for exactly one cycle, resets Rcon to 01, and returns to IDLE.
- Next-key arithmetic (combinational from oRoundKey):
  - t = SubWord(RotWord(w3)) ^ {Rcon,24'h0}, where RotWord is a left rotate by one byte.
  - w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
  - SubWord uses four AES forward S-box instances (same table as the SubBytes stage).
- Rcon:
  - Advances on each transfer with idx<10 via xtime: shift left 1, XOR 8'h1B if the MSB was set.
  - Sequence: 01,02,04,08,10,20,40,80,1B,36.
- Boundary conditions:
  - iStart while RUN is ignored, including the same cycle as the final transfer.
  - iKey changes after start have no effect.
  - iKeyReady while oKeyValid=0 is ignored.
  - iRst_n asserted mid-expansion aborts immediately to the reset values. No oDone is generated.
  - iStart on the cycle oDone=1 (IDLE) is accepted normally.

Optional Feature:
- Macro: AES_KEY_STORE_EN.
- Defined:
  - Adds an 11x128 register file written with each round key as it is transferred.
  - Adds input iRdIdx[3:0] and output oRdKey[127:0]: combinational read of the stored key. Reads 0 for an index that is >10 or not yet written since reset/start.
  - Adds output oStoreValid: set with oDone, cleared by reset or by a new accepted iStart.
  - Lets decryption read keys in reverse order without re-expansion.
- Not defined: no storage, no extra ports; behaviour exactly as above.

Test Plan:
- Reset check: hold iRst_n=0 with random inputs -> all outputs 0. Release, no iStart -> outputs stay 0 and oKeyValid=0.
- FIPS-197 key, iKeyReady=1 constantly:
  - Stimulus: iStart with iKey=2b7e151628aed2a6abf7158809cf4f3c.
  - Required: the cycle after start, idx0=iKey. Next cycle idx1=a0fafe1788542cb123a339392a6c7605. idx10=d014f9a8c9ee2589e13f0cc8b6630ca6 arrives 11 cycles after start.
  - Then oDone=1 for one cycle and oBusy=0.
- Key 000102030405060708090a0b0c0d0e0f with random iKeyReady stalls:
  - idx1=d6aa74fdd2af72fadaa678f1d6ab76fe.
  - idx5=3caaa3e8a99f9deb50f3af57adf622aa.
  - idx10=13111d7fe3944a17f307a78b4d2b30c5.
  - Outputs stay stable throughout every stall. Each round key is also fed to AddRoundKeys and the output is checked against state^key.
- Pulse iStart with a different key at idx4 and at the final-transfer cycle -> ignored. The sequence completes unchanged and exactly one oDone is produced.
- Assert iRst_n=0 at idx6 -> outputs 0 the same cycle and no oDone. After release, a new iStart restarts from idx0 with Rcon=01 (check idx1).
- With AES_KEY_STORE_EN, after the FIPS-197 run:
  - iRdIdx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6; iRdIdx=0 -> 2b7e151628aed2a6abf7158809cf4f3c; iRdIdx=12 -> 0.
  - oStoreValid=1 after the run and clears when a new iStart is accepted.

Source files
------------

// File: rtl/aes_key_expansion.sv
// aes_key_expansion: iterative AES-128 key schedule, one round key per valid/ready transfer.
// Define AES_KEY_STORE_EN to keep all 11 round keys in a readable register file.

module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  // NOTE: the default assignment ahead of the case keeps this block purely combinational (no latch).
  always_comb begin
    out_byte = 8'h00;
    case (in_byte)
      8'h00: out_byte = 8'h63; 8'h01: out_byte = 8'h7c; 8'h02: out_byte = 8'h77; 8'h03: out_byte = 8'h7b;
      8'h04: out_byte = 8'hf2; 8'h05: out_byte = 8'h6b; 8'h06: out_byte = 8'h6f; 8'h07: out_byte = 8'hc5;
      8'h08: out_byte = 8'h30; 8'h09: out_byte = 8'h01; 8'h0a: out_byte = 8'h67; 8'h0b: out_byte = 8'h2b;
      8'h0c: out_byte = 8'hfe; 8'h0d: out_byte = 8'hd7; 8'h0e: out_byte = 8'hab; 8'h0f: out_byte = 8'h76;
      8'h10: out_byte = 8'hca; 8'h11: out_byte = 8'h82; 8'h12: out_byte = 8'hc9; 8'h13: out_byte = 8'h7d;
      8'h14: out_byte = 8'hfa; 8'h15: out_byte = 8'h59; 8'h16: out_byte = 8'h47; 8'h17: out_byte = 8'hf0;
      8'h18: out_byte = 8'had; 8'h19: out_byte = 8'hd4; 8'h1a: out_byte = 8'ha2; 8'h1b: out_byte = 8'haf;
      8'h1c: out_byte = 8'h9c; 8'h1d: out_byte = 8'ha4; 8'h1e: out_byte = 8'h72; 8'h1f: out_byte = 8'hc0;
      8'h20: out_byte = 8'hb7; 8'h21: out_byte = 8'hfd; 8'h22: out_byte = 8'h93; 8'h23: out_byte = 8'h26;
      8'h24: out_byte = 8'h36; 8'h25: out_byte = 8'h3f; 8'h26: out_byte = 8'hf7; 8'h27: out_byte = 8'hcc;
      8'h28: out_byte = 8'h34; 8'h29: out_byte = 8'ha5; 8'h2a: out_byte = 8'he5; 8'h2b: out_byte = 8'hf1;
      8'h2c: out_byte = 8'h71; 8'h2d: out_byte = 8'hd8; 8'h2e: out_byte = 8'h31; 8'h2f: out_byte = 8'h15;
      8'h30: out_byte = 8'h04; 8'h31: out_byte = 8'hc7; 8'h32: out_byte = 8'h23; 8'h33: out_byte = 8'hc3;
      8'h34: out_byte = 8'h18; 8'h35: out_byte = 8'h96; 8'h36: out_byte = 8'h05; 8'h37: out_byte = 8'h9a;
      8'h38: out_byte = 8'h07; 8'h39: out_byte = 8'h12; 8'h3a: out_byte = 8'h80; 8'h3b: out_byte = 8'he2;
      8'h3c: out_byte = 8'heb; 8'h3d: out_byte = 8'h27; 8'h3e: out_byte = 8'hb2; 8'h3f: out_byte = 8'h75;
      8'h40: out_byte = 8'h09; 8'h41: out_byte = 8'h83; 8'h42: out_byte = 8'h2c; 8'h43: out_byte = 8'h1a;
      8'h44: out_byte = 8'h1b; 8'h45: out_byte = 8'h6e; 8'h46: out_byte = 8'h5a; 8'h47: out_byte = 8'ha0;
      8'h48: out_byte = 8'h52; 8'h49: out_byte = 8'h3b; 8'h4a: out_byte = 8'hd6; 8'h4b: out_byte = 8'hb3;
      8'h4c: out_byte = 8'h29; 8'h4d: out_byte = 8'he3; 8'h4e: out_byte = 8'h2f; 8'h4f: out_byte = 8'h84;
      8'h50: out_byte = 8'h53; 8'h51: out_byte = 8'hd1; 8'h52: out_byte = 8'h00; 8'h53: out_byte = 8'hed;
      8'h54: out_byte = 8'h20; 8'h55: out_byte = 8'hfc; 8'h56: out_byte = 8'hb1; 8'h57: out_byte = 8'h5b;
      8'h58: out_byte = 8'h6a; 8'h59: out_byte = 8'hcb; 8'h5a: out_byte = 8'hbe; 8'h5b: out_byte = 8'h39;
      8'h5c: out_byte = 8'h4a; 8'h5d: out_byte = 8'h4c; 8'h5e: out_byte = 8'h58; 8'h5f: out_byte = 8'hcf;
      8'h60: out_byte = 8'hd0; 8'h61: out_byte = 8'hef; 8'h62: out_byte = 8'haa; 8'h63: out_byte = 8'hfb;
      8'h64: out_byte = 8'h43; 8'h65: out_byte = 8'h4d; 8'h66: out_byte = 8'h33; 8'h67: out_byte = 8'h85;
      8'h68: out_byte = 8'h45; 8'h69: out_byte = 8'hf9; 8'h6a: out_byte = 8'h02; 8'h6b: out_byte = 8'h7f;
      8'h6c: out_byte = 8'h50; 8'h6d: out_byte = 8'h3c; 8'h6e: out_byte = 8'h9f; 8'h6f: out_byte = 8'ha8;
      8'h70: out_byte = 8'h51; 8'h71: out_byte = 8'ha3; 8'h72: out_byte = 8'h40; 8'h73: out_byte = 8'h8f;
      8'h74: out_byte = 8'h92; 8'h75: out_byte = 8'h9d; 8'h76: out_byte = 8'h38; 8'h77: out_byte = 8'hf5;
      8'h78: out_byte = 8'hbc; 8'h79: out_byte = 8'hb6; 8'h7a: out_byte = 8'hda; 8'h7b: out_byte = 8'h21;
      8'h7c: out_byte = 8'h10; 8'h7d: out_byte = 8'hff; 8'h7e: out_byte = 8'hf3; 8'h7f: out_byte = 8'hd2;
      8'h80: out_byte = 8'hcd; 8'h81: out_byte = 8'h0c; 8'h82: out_byte = 8'h13; 8'h83: out_byte = 8'hec;
      8'h84: out_byte = 8'h5f; 8'h85: out_byte = 8'h97; 8'h86: out_byte = 8'h44; 8'h87: out_byte = 8'h17;
      8'h88: out_byte = 8'hc4; 8'h89: out_byte = 8'ha7; 8'h8a: out_byte = 8'h7e; 8'h8b: out_byte = 8'h3d;
      8'h8c: out_byte = 8'h64; 8'h8d: out_byte = 8'h5d; 8'h8e: out_byte = 8'h19; 8'h8f: out_byte = 8'h73;
      8'h90: out_byte = 8'h60; 8'h91: out_byte = 8'h81; 8'h92: out_byte = 8'h4f; 8'h93: out_byte = 8'hdc;
      8'h94: out_byte = 8'h22; 8'h95: out_byte = 8'h2a; 8'h96: out_byte = 8'h90; 8'h97: out_byte = 8'h88;
      8'h98: out_byte = 8'h46; 8'h99: out_byte = 8'hee; 8'h9a: out_byte = 8'hb8; 8'h9b: out_byte = 8'h14;
      8'h9c: out_byte = 8'hde; 8'h9d: out_byte = 8'h5e; 8'h9e: out_byte = 8'h0b; 8'h9f: out_byte = 8'hdb;
      8'ha0: out_byte = 8'he0; 8'ha1: out_byte = 8'h32; 8'ha2: out_byte = 8'h3a; 8'ha3: out_byte = 8'h0a;
      8'ha4: out_byte = 8'h49; 8'ha5: out_byte = 8'h06; 8'ha6: out_byte = 8'h24; 8'ha7: out_byte = 8'h5c;
      8'ha8: out_byte = 8'hc2; 8'ha9: out_byte = 8'hd3; 8'haa: out_byte = 8'hac; 8'hab: out_byte = 8'h62;
      8'hac: out_byte = 8'h91; 8'had: out_byte = 8'h95; 8'hae: out_byte = 8'he4; 8'haf: out_byte = 8'h79;
      8'hb0: out_byte = 8'he7; 8'hb1: out_byte = 8'hc8; 8'hb2: out_byte = 8'h37; 8'hb3: out_byte = 8'h6d;
      8'hb4: out_byte = 8'h8d; 8'hb5: out_byte = 8'hd5; 8'hb6: out_byte = 8'h4e; 8'hb7: out_byte = 8'ha9;
      8'hb8: out_byte = 8'h6c; 8'hb9: out_byte = 8'h56; 8'hba: out_byte = 8'hf4; 8'hbb: out_byte = 8'hea;
      8'hbc: out_byte = 8'h65; 8'hbd: out_byte = 8'h7a; 8'hbe: out_byte = 8'hae; 8'hbf: out_byte = 8'h08;
      8'hc0: out_byte = 8'hba; 8'hc1: out_byte = 8'h78; 8'hc2: out_byte = 8'h25; 8'hc3: out_byte = 8'h2e;
      8'hc4: out_byte = 8'h1c; 8'hc5: out_byte = 8'ha6; 8'hc6: out_byte = 8'hb4; 8'hc7: out_byte = 8'hc6;
      8'hc8: out_byte = 8'he8; 8'hc9: out_byte = 8'hdd; 8'hca: out_byte = 8'h74; 8'hcb: out_byte = 8'h1f;
      8'hcc: out_byte = 8'h4b; 8'hcd: out_byte = 8'hbd; 8'hce: out_byte = 8'h8b; 8'hcf: out_byte = 8'h8a;
      8'hd0: out_byte = 8'h70; 8'hd1: out_byte = 8'h3e; 8'hd2: out_byte = 8'hb5; 8'hd3: out_byte = 8'h66;
      8'hd4: out_byte = 8'h48; 8'hd5: out_byte = 8'h03; 8'hd6: out_byte = 8'hf6; 8'hd7: out_byte = 8'h0e;
      8'hd8: out_byte = 8'h61; 8'hd9: out_byte = 8'h35; 8'hda: out_byte = 8'h57; 8'hdb: out_byte = 8'hb9;
      8'hdc: out_byte = 8'h86; 8'hdd: out_byte = 8'hc1; 8'hde: out_byte = 8'h1d; 8'hdf: out_byte = 8'h9e;
      8'he0: out_byte = 8'he1; 8'he1: out_byte = 8'hf8; 8'he2: out_byte = 8'h98; 8'he3: out_byte = 8'h11;
      8'he4: out_byte = 8'h69; 8'he5: out_byte = 8'hd9; 8'he6: out_byte = 8'h8e; 8'he7: out_byte = 8'h94;
      8'he8: out_byte = 8'h9b; 8'he9: out_byte = 8'h1e; 8'hea: out_byte = 8'h87; 8'heb: out_byte = 8'he9;
      8'hec: out_byte = 8'hce; 8'hed: out_byte = 8'h55; 8'hee: out_byte = 8'h28; 8'hef: out_byte = 8'hdf;
      8'hf0: out_byte = 8'h8c; 8'hf1: out_byte = 8'ha1; 8'hf2: out_byte = 8'h89; 8'hf3: out_byte = 8'h0d;
      8'hf4: out_byte = 8'hbf; 8'hf5: out_byte = 8'he6; 8'hf6: out_byte = 8'h42; 8'hf7: out_byte = 8'h68;
      8'hf8: out_byte = 8'h41; 8'hf9: out_byte = 8'h99; 8'hfa: out_byte = 8'h2d; 8'hfb: out_byte = 8'h0f;
      8'hfc: out_byte = 8'hb0; 8'hfd: out_byte = 8'h54; 8'hfe: out_byte = 8'hbb; 8'hff: out_byte = 8'h16;
      default: out_byte = 8'h00;
    endcase
  end
endmodule

module aes_key_expansion #(
  parameter int NR = 10
) (
  input  logic         iClk,
  input  logic         iRst_n,
  input  logic         iStart,
  input  logic [127:0] iKey,
  input  logic         iKeyReady,
  output logic [127:0] oRoundKey,
  output logic [3:0]   oRoundIdx,
  output logic         oKeyValid,
  output logic         oBusy,
  output logic         oDone
`ifdef AES_KEY_STORE_EN
  ,
  input  logic [3:0]   iRdIdx,
  output logic [127:0] oRdKey,
  output logic         oStoreValid
`endif
);

  if (NR != 10) begin : g_nr_unsupported
    $error("aes_key_expansion: only NR=10 (AES-128) is supported");
  end

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [3:0] LAST_IDX = 4'(NR);

  state_e      state;
  logic [7:0]  rcon;
  logic [7:0]  rcon_next;
  logic        xfer;
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w3, sub_w3, t_word;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = oRoundKey;
  assign rot_w3 = {w3[23:0], w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (rot_w3[8*g +: 8]),
      .out_byte (sub_w3[8*g +: 8])
    );
  end

  assign t_word = sub_w3 ^ {rcon, 24'h0};
  assign n0     = w0 ^ t_word;
  assign n1     = w1 ^ n0;
  assign n2     = w2 ^ n1;
  assign n3     = w3 ^ n2;

  // xtime: multiply by x in GF(2^8) modulo the AES polynomial.
  assign rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
  assign xfer      = oKeyValid & iKeyReady;

  // NOTE: every register here uses <= so all updates see the pre-edge values of their peers.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state     <= IDLE;
      oRoundKey <= '0;
      oRoundIdx <= '0;
      oKeyValid <= 1'b0;
      oBusy     <= 1'b0;
      oDone     <= 1'b0;
      rcon      <= 8'h01;
    end else begin
      oDone <= 1'b0;
      case (state)
        IDLE: begin
          if (iStart) begin
            oRoundKey <= iKey;
            oRoundIdx <= '0;
            oKeyValid <= 1'b1;
            oBusy     <= 1'b1;
            rcon      <= 8'h01;
            state     <= RUN;
          end
        end
        RUN: begin
          if (xfer) begin
            if (oRoundIdx != LAST_IDX) begin
              oRoundKey <= {n0, n1, n2, n3};
              oRoundIdx <= oRoundIdx + 4'd1;
              rcon      <= rcon_next;
            end else begin
              oKeyValid <= 1'b0;
              oBusy     <= 1'b0;
              oDone     <= 1'b1;
              rcon      <= 8'h01;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AES_KEY_STORE_EN
  logic [127:0] key_store [0:NR];
  logic [15:0]  key_written;

  // NOTE: the key array itself has no reset; key_written masks stale entries, so it maps to plain storage.
  always_ff @(posedge iClk) begin
    if (state == RUN && xfer) begin
      key_store[oRoundIdx] <= oRoundKey;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      key_written <= '0;
      oStoreValid <= 1'b0;
    end else if (state == IDLE && iStart) begin
      key_written <= '0;
      oStoreValid <= 1'b0;
    end else if (state == RUN && xfer) begin
      key_written[oRoundIdx] <= 1'b1;
      if (oRoundIdx == LAST_IDX) begin
        oStoreValid <= 1'b1;
      end
    end
  end

  always_comb begin
    oRdKey = '0;
    if (iRdIdx <= LAST_IDX && key_written[iRdIdx]) begin
      oRdKey = key_store[iRdIdx];
    end
  end
`endif

endmodule

// File: tb/tb_aes_key_expansion.sv
// Self-checking bench for aes_key_expansion: scoreboard against a GF(2^8)-arithmetic key schedule model.
module tb_aes_key_expansion;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key = '0;
  logic         key_ready = 1'b0;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         key_valid;
  logic         busy;
  logic         done;
`ifdef AES_KEY_STORE_EN
  logic [3:0]   rd_idx = '0;
  logic [127:0] rd_key;
  logic         store_valid;
`endif

  aes_key_expansion #(.NR(10)) dut (
    .iClk      (clk),
    .iRst_n    (rst_n),
    .iStart    (start),
    .iKey      (key),
    .iKeyReady (key_ready),
    .oRoundKey (round_key),
    .oRoundIdx (round_idx),
    .oKeyValid (key_valid),
    .oBusy     (busy),
    .oDone     (done)
`ifdef AES_KEY_STORE_EN
    ,
    .iRdIdx      (rd_idx),
    .oRdKey      (rd_key),
    .oStoreValid (store_valid)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] SEQ_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SEQ_RK1   = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] SEQ_RK5   = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
  localparam logic [127:0] SEQ_RK10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  typedef struct packed {
    logic [127:0] key;
    logic [3:0]   idx;
  } exp_t;

  int           checks = 0;
  int           errors = 0;
  int           done_cnt = 0;
  exp_t         exp_q [$];
  logic [7:0]   sbox_tab [256];
  logic [127:0] model_keys [11];
  logic [127:0] got_keys [16];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  // S-box from first principles: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    for (int v = 0; v < 256; v++) begin
      logic [7:0] b, inv;
      b = 8'(v);
      inv = 8'h00;
      if (b != 8'h00) begin
        inv = 8'h01;
        for (int j = 0; j < 254; j++) inv = gf_mul(inv, b);
      end
      sbox_tab[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) model_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Monitor: pops the scoreboard on every transfer and watches stall stability and oDone width.
  logic         stall_pend = 1'b0;
  logic         prev_done = 1'b0;
  logic [127:0] prev_key;
  logic [3:0]   prev_idx;
  logic [127:0] ark_state;
  exp_t         e;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_pend = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (stall_pend) begin
        check("stall_key", round_key, prev_key);
        check("stall_idx", 128'(round_idx), 128'(prev_idx));
        check("stall_valid", 128'(key_valid), 128'd1);
      end
      if (key_valid && key_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_key got idx=%0d key=%h want no transfer", round_idx, round_key);
        end else begin
          e = exp_q.pop_front();
          check("round_idx", 128'(round_idx), 128'(e.idx));
          check("round_key", round_key, e.key);
          ark_state = {$urandom, $urandom, $urandom, $urandom};
          check("add_round_key", ark_state ^ round_key, ark_state ^ e.key);
        end
        got_keys[round_idx] = round_key;
      end
      stall_pend = key_valid && !key_ready;
      prev_key   = round_key;
      prev_idx   = round_idx;
      if (done) begin
        done_cnt++;
        if (prev_done) begin
          checks++;
          errors++;
          $display("FAIL done_width got=2+ cycles want=1 cycle");
        end
      end
      prev_done = done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_key"},   round_key, 128'd0);
    check({tag, "_idx"},   128'(round_idx), 128'd0);
    check({tag, "_valid"}, 128'(key_valid), 128'd0);
    check({tag, "_busy"},  128'(busy), 128'd0);
    check({tag, "_done"},  128'(done), 128'd0);
  endtask

  // Issues an accepted start: the caller guarantees the DUT is idle.
  task automatic start_expansion(input logic [127:0] k);
    exp_t x;
    model_expand(k);
    for (int r = 0; r < 11; r++) begin
      x.key = model_keys[r];
      x.idx = 4'(r);
      exp_q.push_back(x);
    end
    start = 1'b1;
    key   = k;
    tick();
    start = 1'b0;
    key   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_done(input int budget, input bit rand_ready);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      if (rand_ready) key_ready = ($urandom_range(0, 2) != 0);
      tick();
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout got=no oDone want=oDone within %0d cycles", budget);
    end
  endtask

  task automatic wait_idx(input logic [3:0] target, input int budget);
    for (int c = 0; c < budget && round_idx != target; c++) tick();
    check("reach_idx", 128'(round_idx), 128'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=no finish want=finish");
    $fatal(1);
  end

  initial begin
    int done_ref;
    build_sbox();

    // Reset held with random inputs, then idle with no start.
    rst_n = 1'b0;
    for (int c = 0; c < 5; c++) begin
      start = 1'($urandom);
      key = {$urandom, $urandom, $urandom, $urandom};
      key_ready = 1'($urandom);
      tick();
    end
    check_reset_outputs("rst_hold");
    start = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      key_ready = 1'($urandom);
      tick();
    end
    check_reset_outputs("rst_idle");

    // FIPS-197 key at full throughput.
    key_ready = 1'b1;
    start_expansion(FIPS_KEY);
    check("fips_idx0_valid", 128'(key_valid), 128'd1);
    check("fips_idx0_busy", 128'(busy), 128'd1);
    check("fips_idx0_key", round_key, FIPS_KEY);
    tick();
    check("fips_idx1_idx", 128'(round_idx), 128'd1);
    check("fips_idx1_key", round_key, FIPS_RK1);
    for (int c = 0; c < 9; c++) tick();
    check("fips_idx10_idx", 128'(round_idx), 128'd10);
    check("fips_idx10_key", round_key, FIPS_RK10);
    tick();
    check("fips_done", 128'(done), 128'd1);
    check("fips_done_busy", 128'(busy), 128'd0);
    check("fips_done_valid", 128'(key_valid), 128'd0);
    tick();
    check("fips_done_pulse", 128'(done), 128'd0);
    check("fips_done_cnt", 128'(done_cnt), 128'd1);

`ifdef AES_KEY_STORE_EN
    check("store_valid_set", 128'(store_valid), 128'd1);
    rd_idx = 4'd10; #1;
    check("store_rd10", rd_key, FIPS_RK10);
    rd_idx = 4'd0; #1;
    check("store_rd0", rd_key, FIPS_KEY);
    rd_idx = 4'd12; #1;
    check("store_rd12", rd_key, 128'd0);
`endif

    // Sequential key with random consumer stalls.
    key_ready = 1'($urandom);
    start_expansion(SEQ_KEY);
`ifdef AES_KEY_STORE_EN
    check("store_valid_clr", 128'(store_valid), 128'd0);
    rd_idx = 4'd10; #1;
    check("store_rd10_clr", rd_key, 128'd0);
`endif
    wait_done(300, 1'b1);
    tick();
    check("seq_rk1", got_keys[1], SEQ_RK1);
    check("seq_rk5", got_keys[5], SEQ_RK5);
    check("seq_rk10", got_keys[10], SEQ_RK10);
    check("seq_done_cnt", 128'(done_cnt), 128'd2);

    // Start pulses during RUN (at idx4 and on the final transfer) are ignored.
    key_ready = 1'b1;
    start_expansion({$urandom, $urandom, $urandom, $urandom});
    wait_idx(4'd4, 20);
    start = 1'b1;
    key = {$urandom, $urandom, $urandom, $urandom};
    tick();
    start = 1'b0;
    wait_idx(4'd10, 20);
    start = 1'b1;
    key = {$urandom, $urandom, $urandom, $urandom};
    tick();
    start = 1'b0;
    check("ign_done", 128'(done), 128'd1);
    tick();
    check("ign_valid", 128'(key_valid), 128'd0);
    check("ign_busy", 128'(busy), 128'd0);
    check("ign_done_cnt", 128'(done_cnt), 128'd3);
    check("ign_queue_empty", 128'(exp_q.size()), 128'd0);

    // Reset mid-expansion at idx6.
    start_expansion({$urandom, $urandom, $urandom, $urandom});
    wait_idx(4'd6, 20);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    exp_q.delete();
    done_ref = done_cnt;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("abort_no_done", 128'(done_cnt), 128'(done_ref));
    check("abort_idle_valid", 128'(key_valid), 128'd0);
    start_expansion(FIPS_KEY);
    check("restart_idx0", round_key, FIPS_KEY);
    tick();
    check("restart_idx1", round_key, FIPS_RK1);
    wait_done(20, 1'b0);

    // Start in the cycle oDone is high is accepted.
    start_expansion(SEQ_KEY);
    check("start_on_done_valid", 128'(key_valid), 128'd1);
    check("start_on_done_key", round_key, SEQ_KEY);
    wait_done(20, 1'b0);
    tick();
    check("final_done_cnt", 128'(done_cnt), 128'(done_ref + 2));
    check("final_queue_empty", 128'(exp_q.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
